// File: rtl/mul_sequencer_pkg.sv
// Shared CPU definitions used by the EX-stage multiply sequencer:
// ALU control codes and the sequencer state encoding.
package mul_sequencer_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] MUL_CODE = 4'b0101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// EX-stage multiply handshake: the pipeline side (master) presents the
// decoded instruction and operands, the sequencer (slave) answers with stall/done/result.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);

  logic [3:0]       ALUCtrl_i;
  logic             valid_i;
  logic             flush_i;
  logic [WIDTH-1:0] rs1_data_i;
  logic [WIDTH-1:0] rs2_data_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output ALUCtrl_i, valid_i, flush_i, rs1_data_i, rs2_data_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  ALUCtrl_i, valid_i, flush_i, rs1_data_i, rs2_data_i,
    output stall_o, done_o, result_o
  );

endinterface

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add datapath: one partial product is accumulated per step,
// all arithmetic modulo 2^WIDTH.
module mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_next_o
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Accumulator value after the current step; also feeds the result register.
  assign acc_next_o = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load_i) begin
      acc    <= '0;
      mcand  <= mcand_i;
      mplier <= mplier_i;
    end else if (step_i) begin
      acc    <= acc_next_o;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative MUL controller for EX: captures operands, stalls the pipeline for a
// fixed WIDTH-iteration shift-add, then presents the low product half for one cycle.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mul_sequencer_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_e       state;
  mul_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             last;
  logic             load;
  logic             step;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] result;

  assign req  = bus.valid_i & (bus.ALUCtrl_i == MUL_CODE) & ~bus.flush_i;
  assign last = (cnt == '0);

  mul_shift_add #(.WIDTH(WIDTH)) u_datapath (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .step_i     (step),
    .mcand_i    (bus.rs1_data_i),
    .mplier_i   (bus.rs2_data_i),
    .acc_next_o (acc_next)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.flush_i) begin
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
          step  = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        // A squashed MUL must not be written back, even in its completion cycle.
        done      = ~bus.flush_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (load)
        cnt <= CNT_W'(WIDTH - 1);
      else if (step && !last)
        cnt <= cnt - CNT_W'(1);
      if (step && last)
        result <= acc_next;
    end
  end

  assign bus.stall_o  = stall & ~rst_i;
  assign bus.done_o   = done;
  assign bus.result_o = result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a cycle-count/product model.
module tb_mul_sequencer;

  localparam int         W     = 32;
  localparam logic [3:0] C_MUL = 4'b0101;
  localparam logic [3:0] C_ADD = 4'b0011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting, 1..W = iterating, W+1 = completion cycle.
  int          phase = 0;
  logic [31:0] m_prod = '0;
  logic [31:0] m_res = '0;

  always @(negedge clk) begin
    logic req;
    logic e_stall, e_done;
    req = bus.valid_i && (bus.ALUCtrl_i == C_MUL) && !bus.flush_i;
    if (rst) begin
      phase = 0;
      m_res = '0;
      check("rst_stall", 32'(bus.stall_o), 32'd0);
      check("rst_done", 32'(bus.done_o), 32'd0);
      check("rst_result", bus.result_o, 32'd0);
    end else begin
      e_stall = 1'b0;
      e_done  = 1'b0;
      if (phase == 0)           e_stall = req;
      else if (phase <= W)      e_stall = !bus.flush_i;
      else                      e_done  = !bus.flush_i;
      check("stall", 32'(bus.stall_o), 32'(e_stall));
      check("done", 32'(bus.done_o), 32'(e_done));
      check("result", bus.result_o, m_res);
      if (phase == 0) begin
        if (req) begin
          phase  = 1;
          m_prod = bus.rs1_data_i * bus.rs2_data_i;
        end
      end else if (phase <= W) begin
        if (bus.flush_i) phase = 0;
        else if (phase == W) begin
          phase = W + 1;
          m_res = m_prod;
        end else phase = phase + 1;
      end else begin
        phase = 0;
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] c, input logic f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_i    = v;
    bus.ALUCtrl_i  = c;
    bus.flush_i    = f;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 4'b0000, 1'b0, '0, '0);
    end
  endtask

  // Issues a MUL; lat is the done cycle relative to the request cycle (-1 on timeout).
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stalls, output logic [31:0] res);
    @(posedge clk); #1;
    drive(1'b1, C_MUL, 1'b0, a, b);
    lat    = -1;
    stalls = 0;
    res    = '0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (bus.stall_o) stalls++;
      if (bus.done_o) begin
        lat = i;
        res = bus.result_o;
        break;
      end
    end
  endtask

  task automatic count_done(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
  endtask

  initial begin
    int          lat, stalls, dones, n_stall;
    logic [31:0] res;
    drive(1'b0, 4'b0000, 1'b0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    check("init_stall", 32'(bus.stall_o), 32'd0);
    check("init_result", bus.result_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    run_mul(32'd3, 32'd5, lat, stalls, res);
    check("basic_latency", 32'(lat), 32'd33);
    check("basic_stall_cycles", 32'(stalls), 32'd33);
    check("basic_result", res, 32'h0000000F);
    idle(1);

    run_mul(32'hFFFFFFFF, 32'h00000002, lat, stalls, res);
    check("wrap_result", res, 32'hFFFFFFFE);
    idle(1);

    run_mul(32'hFFFFFFFD, 32'h00000007, lat, stalls, res);
    check("signed_result", res, 32'hFFFFFFEB);
    idle(1);

    run_mul(32'd6, 32'd7, lat, stalls, res);
    check("b2b_first_latency", 32'(lat), 32'd33);
    check("b2b_first_result", res, 32'h0000002A);
    run_mul(32'd2, 32'd2, lat, stalls, res);
    check("b2b_second_latency", 32'(lat), 32'd33);
    check("b2b_second_result", res, 32'h00000004);

    n_stall = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(1'b1, C_ADD, 1'b0, 32'd9, 32'd9);
      @(negedge clk);
      if (bus.stall_o) n_stall++;
    end
    check("add_no_stall", 32'(n_stall), 32'd0);

    // Flush ten cycles into an operation.
    @(posedge clk); #1;
    drive(1'b1, C_MUL, 1'b0, 32'd9, 32'd9);
    repeat (10) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_stall_low", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 4'b0000, 1'b0, '0, '0);
    @(negedge clk);
    check("flush_idle_next", 32'(bus.stall_o), 32'd0);
    count_done(40, dones);
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_result_kept", bus.result_o, 32'h00000004);

    // Reset five cycles into an operation.
    @(posedge clk); #1;
    drive(1'b1, C_MUL, 1'b0, 32'h1234, 32'h10);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_stall", 32'(bus.stall_o), 32'd0);
    check("midrst_result", bus.result_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, '0, '0);
    count_done(40, dones);
    check("midrst_no_done", 32'(dones), 32'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      int          sel;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 999) < 2);
      sel = int'($urandom_range(0, 3));
      c   = (sel == 0) ? 4'($urandom) : C_MUL;
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) b = '0;
      drive($urandom_range(0, 3) != 0, c, $urandom_range(0, 99) == 0, a, b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
